// File: rtl/pending_encoder_16x4_if.sv
// Request/handshake bundle between event sources, the pending encoder and the index consumer.
// The master drives requests, enable and ready; the slave (encoder) returns the served index.
interface pending_encoder_16x4_if #(
  parameter int N      = 16,
  parameter int CODE_W = 4
);
  logic [N-1:0]      req_in;
  logic              en;
  logic              ready;
  logic              valid;
  logic [CODE_W-1:0] code;
  logic [N-1:0]      pending;
  logic              dropped;

  modport master (
    output req_in, en, ready,
    input  valid, code, pending, dropped
  );

  modport slave (
    input  req_in, en, ready,
    output valid, code, pending, dropped
  );
endinterface

// File: rtl/pending_encoder_16x4.sv
// Sequential 16-to-4 encoder: latches request pulses into a sticky pending set and
// serves one fixed-priority binary index per valid/ready transaction.
module pending_encoder_16x4 #(
  parameter int N         = 16,
  parameter int CODE_W    = 4,
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pending_encoder_16x4_if.slave bus
);

  if (N != (1 << CODE_W)) begin : g_bad_width
    $error("pending_encoder_16x4: N must equal 2**CODE_W");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state;
  logic [N-1:0]      pending_q;
  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  logic              dropped_q;

  logic [CODE_W-1:0] pick;
  logic              any_pending;
  logic              load;
  logic [N-1:0]      take_mask;

  // Priority pick looks only at the registered pending set, never at same-cycle req_in.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pick = '0;
    if (LOW_FIRST) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (pending_q[i]) pick = CODE_W'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (pending_q[i]) pick = CODE_W'(i);
      end
    end
  end

  assign any_pending = |pending_q;

  // A new index loads from IDLE whenever enabled, or from HOLD only as the shown code is accepted.
  always_comb begin
    load = 1'b0;
    case (state)
      IDLE:    load = bus.en & any_pending;
      HOLD:    load = bus.ready & bus.en & any_pending;
      default: load = 1'b0;
    endcase
  end

  always_comb begin
    take_mask = '0;
    if (load) take_mask[pick] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      // Set wins over take: a pulse on the bit being served re-arms it as a fresh event.
      pending_q <= (pending_q & ~take_mask) | bus.req_in;
      dropped_q <= |(bus.req_in & pending_q & ~take_mask);

      case (state)
        IDLE: begin
          if (load) begin
            code_q  <= pick;
            valid_q <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (bus.ready) begin
            if (load) begin
              code_q <= pick;
            end else begin
              valid_q <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.valid   = valid_q;
  assign bus.code    = code_q;
  assign bus.pending = pending_q;
  assign bus.dropped = dropped_q;

endmodule

// File: tb/tb_pending_encoder_16x4.sv
// Directed self-checking bench for pending_encoder_16x4: one low-first and one high-first
// instance share stimulus; each scenario task checks hand-computed values after the edge.
module tb_pending_encoder_16x4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pending_encoder_16x4_if #(.N(16), .CODE_W(4)) bus_lo ();
  pending_encoder_16x4_if #(.N(16), .CODE_W(4)) bus_hi ();

  assign bus_hi.req_in = bus_lo.req_in;
  assign bus_hi.en     = bus_lo.en;
  assign bus_hi.ready  = bus_lo.ready;

  pending_encoder_16x4 #(.N(16), .CODE_W(4), .LOW_FIRST(1'b1)) dut_lo (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_lo)
  );

  pending_encoder_16x4 #(.N(16), .CODE_W(4), .LOW_FIRST(1'b0)) dut_hi (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus_lo.req_in = '0;
    bus_lo.en     = 1'b1;
    bus_lo.ready  = 1'b1;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus_lo.valid !== 1'b0 || bus_lo.code !== 4'd0 || bus_lo.pending !== 16'h0000 || bus_lo.dropped !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b code=%0d pending=%h dropped=%b expected 0/0/0000/0",
               bus_lo.valid, bus_lo.code, bus_lo.pending, bus_lo.dropped);
    end
    bus_lo.ready  = 1'b0;
    bus_lo.req_in = 16'h0003;
    step();
    bus_lo.req_in = '0;
    step();
    checks++;
    if (bus_lo.valid !== 1'b1 || bus_lo.code !== 4'd0 || bus_lo.pending !== 16'h0002) begin
      errors++;
      $display("FAIL reset_prehold: valid=%b code=%0d pending=%h expected 1/0/0002",
               bus_lo.valid, bus_lo.code, bus_lo.pending);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus_lo.valid !== 1'b0 || bus_lo.code !== 4'd0 || bus_lo.pending !== 16'h0000) begin
      errors++;
      $display("FAIL reset_async: valid=%b code=%0d pending=%h expected 0/0/0000",
               bus_lo.valid, bus_lo.code, bus_lo.pending);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    bus_lo.req_in = 16'h0020;
    step();
    bus_lo.req_in = '0;
    checks++;
    if (bus_lo.valid !== 1'b0 || bus_lo.pending !== 16'h0020) begin
      errors++;
      $display("FAIL single_latch: valid=%b pending=%h expected 0/0020", bus_lo.valid, bus_lo.pending);
    end
    step();
    checks++;
    if (bus_lo.valid !== 1'b1 || bus_lo.code !== 4'd5 || bus_lo.pending !== 16'h0000) begin
      errors++;
      $display("FAIL single_serve: valid=%b code=%0d pending=%h expected 1/5/0000",
               bus_lo.valid, bus_lo.code, bus_lo.pending);
    end
    step();
    checks++;
    if (bus_lo.valid !== 1'b0 || bus_lo.pending !== 16'h0000 || bus_lo.dropped !== 1'b0) begin
      errors++;
      $display("FAIL single_done: valid=%b pending=%h dropped=%b expected 0/0000/0",
               bus_lo.valid, bus_lo.pending, bus_lo.dropped);
    end
  endtask

  task automatic test_multi();
    logic [3:0] exp_lo [3];
    logic [3:0] exp_hi [3];
    exp_lo = '{4'd0, 4'd8, 4'd15};
    exp_hi = '{4'd15, 4'd8, 4'd0};
    do_reset();
    bus_lo.req_in = 16'h8101;
    step();
    bus_lo.req_in = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus_lo.valid !== 1'b1 || bus_lo.code !== exp_lo[i]) begin
        errors++;
        $display("FAIL multi_low[%0d]: valid=%b code=%0d expected 1/%0d", i, bus_lo.valid, bus_lo.code, exp_lo[i]);
      end
      checks++;
      if (bus_hi.valid !== 1'b1 || bus_hi.code !== exp_hi[i]) begin
        errors++;
        $display("FAIL multi_high[%0d]: valid=%b code=%0d expected 1/%0d", i, bus_hi.valid, bus_hi.code, exp_hi[i]);
      end
    end
    step();
    checks++;
    if (bus_lo.valid !== 1'b0 || bus_hi.valid !== 1'b0) begin
      errors++;
      $display("FAIL multi_done: valid_lo=%b valid_hi=%b expected 0/0", bus_lo.valid, bus_hi.valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus_lo.ready  = 1'b0;
    bus_lo.req_in = 16'h0006;
    step();
    bus_lo.req_in = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus_lo.valid !== 1'b1 || bus_lo.code !== 4'd1 || bus_lo.pending !== 16'h0004) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b code=%0d pending=%h expected 1/1/0004",
                 i, bus_lo.valid, bus_lo.code, bus_lo.pending);
      end
    end
    bus_lo.ready = 1'b1;
    step();
    checks++;
    if (bus_lo.valid !== 1'b1 || bus_lo.code !== 4'd2 || bus_lo.pending !== 16'h0000) begin
      errors++;
      $display("FAIL bp_next: valid=%b code=%0d pending=%h expected 1/2/0000",
               bus_lo.valid, bus_lo.code, bus_lo.pending);
    end
    step();
    checks++;
    if (bus_lo.valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_done: valid=%b expected 0", bus_lo.valid);
    end
  endtask

  task automatic test_drop_rearm();
    do_reset();
    bus_lo.ready  = 1'b0;
    bus_lo.req_in = 16'h0009;
    step();
    bus_lo.req_in = '0;
    step();
    checks++;
    if (bus_lo.code !== 4'd0 || bus_lo.pending !== 16'h0008 || bus_lo.dropped !== 1'b0) begin
      errors++;
      $display("FAIL drop_setup: code=%0d pending=%h dropped=%b expected 0/0008/0",
               bus_lo.code, bus_lo.pending, bus_lo.dropped);
    end
    bus_lo.req_in = 16'h0008;
    step();
    bus_lo.req_in = '0;
    checks++;
    if (bus_lo.dropped !== 1'b1) begin
      errors++;
      $display("FAIL drop_pulse: dropped=%b expected 1", bus_lo.dropped);
    end
    step();
    checks++;
    if (bus_lo.dropped !== 1'b0 || bus_lo.pending !== 16'h0008) begin
      errors++;
      $display("FAIL drop_clear: dropped=%b pending=%h expected 0/0008", bus_lo.dropped, bus_lo.pending);
    end
    // Accept code 0 on the same edge bit 3 is taken and re-pulsed.
    bus_lo.ready  = 1'b1;
    bus_lo.req_in = 16'h0008;
    step();
    bus_lo.req_in = '0;
    checks++;
    if (bus_lo.valid !== 1'b1 || bus_lo.code !== 4'd3 || bus_lo.pending !== 16'h0008 || bus_lo.dropped !== 1'b0) begin
      errors++;
      $display("FAIL rearm_take: valid=%b code=%0d pending=%h dropped=%b expected 1/3/0008/0",
               bus_lo.valid, bus_lo.code, bus_lo.pending, bus_lo.dropped);
    end
    step();
    checks++;
    if (bus_lo.valid !== 1'b1 || bus_lo.code !== 4'd3 || bus_lo.pending !== 16'h0000 || bus_lo.dropped !== 1'b0) begin
      errors++;
      $display("FAIL rearm_again: valid=%b code=%0d pending=%h dropped=%b expected 1/3/0000/0",
               bus_lo.valid, bus_lo.code, bus_lo.pending, bus_lo.dropped);
    end
    step();
    checks++;
    if (bus_lo.valid !== 1'b0) begin
      errors++;
      $display("FAIL rearm_done: valid=%b expected 0", bus_lo.valid);
    end
  endtask

  task automatic test_enable();
    logic [3:0] exp_codes [4];
    exp_codes = '{4'd4, 4'd5, 4'd6, 4'd7};
    do_reset();
    bus_lo.en     = 1'b0;
    bus_lo.req_in = 16'h00F0;
    step();
    bus_lo.req_in = '0;
    repeat (3) step();
    checks++;
    if (bus_lo.valid !== 1'b0 || bus_lo.pending !== 16'h00F0) begin
      errors++;
      $display("FAIL en_frozen: valid=%b pending=%h expected 0/00F0", bus_lo.valid, bus_lo.pending);
    end
    bus_lo.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus_lo.valid !== 1'b1 || bus_lo.code !== exp_codes[i]) begin
        errors++;
        $display("FAIL en_codes[%0d]: valid=%b code=%0d expected 1/%0d", i, bus_lo.valid, bus_lo.code, exp_codes[i]);
      end
    end
    step();
    checks++;
    if (bus_lo.valid !== 1'b0) begin
      errors++;
      $display("FAIL en_drain: valid=%b expected 0", bus_lo.valid);
    end
    // en drops while a code is held: it completes on ready, then the encoder idles.
    bus_lo.ready  = 1'b0;
    bus_lo.req_in = 16'h0003;
    step();
    bus_lo.req_in = '0;
    step();
    bus_lo.en    = 1'b0;
    bus_lo.ready = 1'b1;
    checks++;
    if (bus_lo.valid !== 1'b1 || bus_lo.code !== 4'd0) begin
      errors++;
      $display("FAIL en_hold: valid=%b code=%0d expected 1/0", bus_lo.valid, bus_lo.code);
    end
    step();
    checks++;
    if (bus_lo.valid !== 1'b0 || bus_lo.pending !== 16'h0002) begin
      errors++;
      $display("FAIL en_complete: valid=%b pending=%h expected 0/0002", bus_lo.valid, bus_lo.pending);
    end
    step();
    bus_lo.en = 1'b1;
    step();
    checks++;
    if (bus_lo.valid !== 1'b1 || bus_lo.code !== 4'd1) begin
      errors++;
      $display("FAIL en_resume: valid=%b code=%0d expected 1/1", bus_lo.valid, bus_lo.code);
    end
  endtask

  task automatic test_full();
    do_reset();
    bus_lo.ready  = 1'b0;
    bus_lo.req_in = 16'hFFFF;
    step();
    checks++;
    if (bus_lo.pending !== 16'hFFFF || bus_lo.dropped !== 1'b0) begin
      errors++;
      $display("FAIL full_set: pending=%h dropped=%b expected FFFF/0", bus_lo.pending, bus_lo.dropped);
    end
    bus_lo.req_in = 16'h0000;
    step();
    bus_lo.req_in = 16'h8000;
    step();
    bus_lo.req_in = '0;
    checks++;
    if (bus_lo.dropped !== 1'b1 || bus_lo.pending !== 16'hFFFE || bus_lo.code !== 4'd0) begin
      errors++;
      $display("FAIL full_drop: dropped=%b pending=%h code=%0d expected 1/FFFE/0",
               bus_lo.dropped, bus_lo.pending, bus_lo.code);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus_lo.req_in = '0;
    bus_lo.en     = 1'b1;
    bus_lo.ready  = 1'b1;
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_drop_rearm();
    test_enable();
    test_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
